knn_classify_datapath: RTL and testbench

Datapath-side responder to the kNN control FSM. Follows the `state` and `address` buses the controller drives. Scans a synchronous sample memory during the scan phase and keeps the three nearest samples to a query point by Manhattan distance. Emits a majority-vote class label when the output phase begins.

---
 rtl/knn_classify_datapath_if.sv | 34 +++
 rtl/knn_classify_datapath.sv | 196 +++++++++++++++++++
 tb/tb_knn_classify_datapath.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_classify_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : knn_classify_datapath_if
// Description : Sample-memory read bus between the kNN datapath (master,
//               issues reads) and the synchronous sample memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface knn_classify_datapath_if #(
    parameter int FEAT_W  = 8,
    parameter int LABEL_W = 2
) ();
    logic [6:0]         mem_addr;
    logic               mem_rd_en;
    logic [FEAT_W-1:0]  mem_x;
    logic [FEAT_W-1:0]  mem_y;
    logic [LABEL_W-1:0] mem_label;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_x,
        input  mem_y,
        input  mem_label
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_x,
        output mem_y,
        output mem_label
    );
endinterface
`default_nettype wire

// File: rtl/knn_classify_datapath.sv
`default_nettype none
// ============================================================================
// Module      : knn_classify_datapath
// Description : Scans sample memory, keeps the three nearest samples to the
//               query (Manhattan distance) and emits a majority-vote label.
// Revision    : 1.0 - initial release
// ============================================================================
module knn_classify_datapath #(
    parameter int FEAT_W      = 8,
    parameter int LABEL_W     = 2,
    parameter int NUM_SAMPLES = 100
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire  [1:0]               state,
    input  wire  [6:0]               address,
    input  wire  [FEAT_W-1:0]        query_x,
    input  wire  [FEAT_W-1:0]        query_y,
    knn_classify_datapath_if.master  mem,
    output logic [LABEL_W-1:0]       class_out,
    output logic [FEAT_W:0]          nearest_dist,
    output logic                     class_valid
);

    localparam int               DIST_W     = FEAT_W + 1;
    localparam logic [1:0]       c_ST_SCAN  = 2'b01;
    localparam logic [1:0]       c_ST_VOTE  = 2'b11;
    localparam logic [6:0]       c_NUM      = 7'(NUM_SAMPLES);
    localparam logic [DIST_W-1:0] c_DIST_MAX = '1;

    function automatic logic [FEAT_W-1:0] abs_diff(input logic [FEAT_W-1:0] a,
                                                   input logic [FEAT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // ------------------------------------------------------------------
    // Read issue and scan control
    // ------------------------------------------------------------------
    logic w_rd_en;
    logic w_scan_start;
    logic w_vote_start;

    assign w_rd_en      = (state == c_ST_SCAN) && (address < c_NUM);
    assign w_scan_start = (state == c_ST_SCAN) && (address == 7'd0);

    assign mem.mem_addr  = address;
    assign mem.mem_rd_en = w_rd_en;

    logic              r_prev_vote;
    logic              r_rd_pend;
    logic [FEAT_W-1:0] r_qx;
    logic [FEAT_W-1:0] r_qy;

    assign w_vote_start = (state == c_ST_VOTE) && !r_prev_vote;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_vote <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_qx        <= '0;
            r_qy        <= '0;
        end else begin
            r_prev_vote <= (state == c_ST_VOTE);
            r_rd_pend   <= w_rd_en;
            if (w_scan_start) begin
                r_qx <= query_x;
                r_qy <= query_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: distance of the sample returned by memory this cycle
    // ------------------------------------------------------------------
    logic [DIST_W-1:0]  w_dist;
    logic [DIST_W-1:0]  r_a_dist;
    logic [LABEL_W-1:0] r_a_label;
    logic               r_a_valid;

    assign w_dist = {1'b0, abs_diff(mem.mem_x, r_qx)} + {1'b0, abs_diff(mem.mem_y, r_qy)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_dist  <= '0;
            r_a_label <= '0;
            r_a_valid <= 1'b0;
        end else begin
            r_a_dist  <= w_dist;
            r_a_label <= mem.mem_label;
            r_a_valid <= r_rd_pend;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: sorted top-3 list, E0 nearest
    // ------------------------------------------------------------------
    logic [DIST_W-1:0]  r_e_dist  [3];
    logic [LABEL_W-1:0] r_e_label [3];
    logic               r_e_vld   [3];

    logic [DIST_W-1:0]  w_base_dist  [3];
    logic [LABEL_W-1:0] w_base_label [3];
    logic               w_base_vld   [3];
    logic               w_lt         [3];
    logic [DIST_W-1:0]  w_nxt_dist   [3];
    logic [LABEL_W-1:0] w_nxt_label  [3];
    logic               w_nxt_vld    [3];

    // Invalid entries carry the all-ones distance, which no real sample can
    // reach, so a plain strict compare also finds the first empty slot.
    // Because the list is sorted, w_lt is monotone: once true it stays true.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_base_dist[i]  = w_scan_start ? c_DIST_MAX : r_e_dist[i];
            w_base_label[i] = w_scan_start ? '0         : r_e_label[i];
            w_base_vld[i]   = w_scan_start ? 1'b0       : r_e_vld[i];
            w_lt[i]         = r_a_valid && (r_a_dist < w_base_dist[i]);
        end

        w_nxt_dist[0]  = w_lt[0] ? r_a_dist  : w_base_dist[0];
        w_nxt_label[0] = w_lt[0] ? r_a_label : w_base_label[0];
        w_nxt_vld[0]   = w_lt[0] ? 1'b1      : w_base_vld[0];

        for (int i = 1; i < 3; i++) begin
            if (w_lt[i-1]) begin
                w_nxt_dist[i]  = w_base_dist[i-1];
                w_nxt_label[i] = w_base_label[i-1];
                w_nxt_vld[i]   = w_base_vld[i-1];
            end else if (w_lt[i]) begin
                w_nxt_dist[i]  = r_a_dist;
                w_nxt_label[i] = r_a_label;
                w_nxt_vld[i]   = 1'b1;
            end else begin
                w_nxt_dist[i]  = w_base_dist[i];
                w_nxt_label[i] = w_base_label[i];
                w_nxt_vld[i]   = w_base_vld[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                r_e_dist[i]  <= c_DIST_MAX;
                r_e_label[i] <= '0;
                r_e_vld[i]   <= 1'b0;
            end else begin
                r_e_dist[i]  <= w_nxt_dist[i];
                r_e_label[i] <= w_nxt_label[i];
                r_e_vld[i]   <= w_nxt_vld[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Vote over the valid entries of the current list
    // ------------------------------------------------------------------
    logic               w_m01;
    logic               w_m02;
    logic               w_m12;
    logic [LABEL_W-1:0] w_vote_label;
    logic [DIST_W-1:0]  w_vote_dist;

    assign w_m01 = r_e_vld[0] && r_e_vld[1] && (r_e_label[0] == r_e_label[1]);
    assign w_m02 = r_e_vld[0] && r_e_vld[2] && (r_e_label[0] == r_e_label[2]);
    assign w_m12 = r_e_vld[1] && r_e_vld[2] && (r_e_label[1] == r_e_label[2]);

    always_comb begin
        w_vote_label = '0;
        if (w_m01 || w_m02) begin
            w_vote_label = r_e_label[0];
        end else if (w_m12) begin
            w_vote_label = r_e_label[1];
        end else if (r_e_vld[0]) begin
            w_vote_label = r_e_label[0];
        end
    end

    assign w_vote_dist = r_e_vld[0] ? r_e_dist[0] : c_DIST_MAX;

    always_ff @(posedge clk) begin
        if (!rst) begin
            class_out    <= '0;
            nearest_dist <= '0;
            class_valid  <= 1'b0;
        end else begin
            class_valid <= w_vote_start;
            if (w_vote_start) begin
                class_out    <= w_vote_label;
                nearest_dist <= w_vote_dist;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_classify_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_classify_datapath
// Description : Randomised and directed bench for knn_classify_datapath with
//               a sort-and-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_classify_datapath;
    localparam int FEAT_W      = 8;
    localparam int LABEL_W     = 2;
    localparam int NUM_SAMPLES = 100;
    localparam int c_DMAX      = (1 << (FEAT_W + 1)) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         state;
    logic [6:0]         address;
    logic [FEAT_W-1:0]  query_x;
    logic [FEAT_W-1:0]  query_y;
    logic [LABEL_W-1:0] class_out;
    logic [FEAT_W:0]    nearest_dist;
    logic               class_valid;

    knn_classify_datapath_if #(.FEAT_W(FEAT_W), .LABEL_W(LABEL_W)) mem_bus ();

    knn_classify_datapath #(
        .FEAT_W(FEAT_W), .LABEL_W(LABEL_W), .NUM_SAMPLES(NUM_SAMPLES)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .address(address),
        .query_x(query_x), .query_y(query_y), .mem(mem_bus),
        .class_out(class_out), .nearest_dist(nearest_dist), .class_valid(class_valid)
    );

    always #5 clk = ~clk;

    // Synchronous sample memory: data for the address of cycle t appears in t+1
    int mx [128];
    int my [128];
    int ml [128];
    always @(posedge clk) begin
        mem_bus.mem_x     <= FEAT_W'(mx[mem_bus.mem_addr]);
        mem_bus.mem_y     <= FEAT_W'(my[mem_bus.mem_addr]);
        mem_bus.mem_label <= LABEL_W'(ml[mem_bus.mem_addr]);
    end

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int got_class;
    int got_dist;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: record every sample read since the scan started, then
    // pick the three smallest distances (earliest wins ties) and count labels.
    int   rq_d[$];
    int   rq_l[$];
    int   m_qx, m_qy;
    logic m_cv;
    int   m_class, m_dist;
    logic m_prev_vote;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_vote();
        int used[$];
        int pick_d[3];
        int pick_l[3];
        int cnt[4];
        int n = 0;
        foreach (rq_d[i]) used.push_back(0);
        for (int k = 0; k < 3; k++) begin
            int best = -1;
            foreach (rq_d[i])
                if (used[i] == 0 && (best < 0 || rq_d[i] < rq_d[best])) best = i;
            if (best >= 0) begin
                used[best] = 1;
                pick_d[n] = rq_d[best];
                pick_l[n] = rq_l[best];
                n++;
            end
        end
        if (n == 0) begin
            m_class = 0;
            m_dist  = c_DMAX;
        end else begin
            m_class = pick_l[0];
            m_dist  = pick_d[0];
            for (int i = 0; i < 4; i++) cnt[i] = 0;
            for (int i = 0; i < n; i++) cnt[pick_l[i]]++;
            for (int i = 0; i < 4; i++) if (cnt[i] >= 2) m_class = i;
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_cv = 1'b0; m_class = 0; m_dist = 0; m_prev_vote = 1'b0;
            m_qx = 0; m_qy = 0;
            rq_d.delete(); rq_l.delete();
        end else begin
            m_cv = 1'b0;
            if (state == 2'b11 && !m_prev_vote) begin
                model_vote();
                m_cv = 1'b1;
            end
            m_prev_vote = (state == 2'b11);
            if (state == 2'b01 && address == 7'd0) begin
                rq_d.delete(); rq_l.delete();
                m_qx = int'(query_x);
                m_qy = int'(query_y);
            end
            if (state == 2'b01 && int'(address) < NUM_SAMPLES) begin
                rq_d.push_back(iabs(mx[address] - m_qx) + iabs(my[address] - m_qy));
                rq_l.push_back(ml[address]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_rd_en", 32'(mem_bus.mem_rd_en),
                32'(state == 2'b01 && int'(address) < NUM_SAMPLES));
            chk("mem_addr", 32'(mem_bus.mem_addr), 32'(address));
            chk("class_valid", 32'(class_valid), 32'(m_cv));
            chk("class_out", 32'(class_out), m_class);
            chk("nearest_dist", 32'(nearest_dist), m_dist);
            if (class_valid === 1'b1) begin
                pulses++;
                got_class = int'(class_out);
                got_dist  = int'(nearest_dist);
            end
        end
    end

    task automatic cyc(input logic [1:0] st, input int addr);
        state   = st;
        address = 7'(addr);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fill(input int x, input int y, input int l, input int qx, input int qy);
        for (int a = 0; a < 128; a++) begin
            if (a < NUM_SAMPLES) begin
                mx[a] = x; my[a] = y; ml[a] = l;
            end else begin
                mx[a] = qx; my[a] = qy; ml[a] = 3;
            end
        end
    endtask

    task automatic run_scan(input int qx, input int qy, input int last, input int gap_pct);
        query_x = FEAT_W'(qx);
        query_y = FEAT_W'(qy);
        for (int a = 0; a <= last; a++) begin
            if (a > 0 && $urandom_range(99) < gap_pct)
                cyc(2'($urandom_range(0, 1) * 2), $urandom_range(127));
            cyc(2'b01, a);
        end
    endtask

    task automatic finish_round(input int settle, input int vote_len);
        int p0 = pulses;
        for (int i = 0; i < settle; i++) cyc(2'b10, $urandom_range(127));
        for (int i = 0; i < vote_len; i++) cyc(2'b11, $urandom_range(127));
        cyc(2'b00, $urandom_range(127));
        cyc(2'b00, $urandom_range(127));
        chk("pulse_count", 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        rst = 1'b0; state = 2'b01; address = 7'd5;
        query_x = '0; query_y = '0;
        fill(200, 200, 1, 0, 0);

        // Reset held with SCAN at address 5
        cyc(2'b01, 5);
        chk_en = 1'b1;
        cyc(2'b01, 5);
        cyc(2'b01, 5);
        chk("rst_class_valid", 32'(class_valid), 32'd0);
        chk("rst_class_out", 32'(class_out), 32'd0);
        chk("rst_nearest_dist", 32'(nearest_dist), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_bus.mem_rd_en), 32'd1);
        chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd5);
        rst = 1'b1;
        cyc(2'b00, 0);

        // Cluster around (10,10)
        fill(200, 200, 1, 10, 10);
        mx[5] = 11; my[5] = 10; ml[5] = 2;
        mx[6] = 10; my[6] = 12; ml[6] = 2;
        mx[7] = 9;  my[7] = 9;  ml[7] = 3;
        run_scan(10, 10, 127, 0);
        finish_round(2, 1);
        chk("cluster_class", 32'(got_class), 32'd2);
        chk("cluster_dist", 32'(got_dist), 32'd1);

        // All labels different with a distance tie
        fill(255, 255, 0, 0, 0);
        mx[3] = 2; my[3] = 2; ml[3] = 0;
        mx[8] = 4; my[8] = 0; ml[8] = 1;
        mx[9] = 1; my[9] = 0; ml[9] = 2;
        run_scan(0, 0, 127, 10);
        finish_round(3, 2);
        chk("tie_class", 32'(got_class), 32'd2);
        chk("tie_dist", 32'(got_dist), 32'd1);

        // Mid-scan reset, then vote on an empty list
        fill(30, 40, 2, 30, 40);
        query_x = 8'd30; query_y = 8'd40;
        for (int a = 0; a < 50; a++) cyc(2'b01, a);
        rst = 1'b0;
        cyc(2'b01, 50);
        rst = 1'b1;
        chk("midrst_class_out", 32'(class_out), 32'd0);
        cyc(2'b00, 51);
        finish_round(2, 1);
        chk("empty_class", 32'(got_class), 32'd0);
        chk("empty_dist", 32'(got_dist), 32'(c_DMAX));

        // Fresh scan with a new query after the reset
        for (int a = 0; a < 128; a++) begin
            mx[a] = (a < NUM_SAMPLES) ? 0 : 100;
            my[a] = (a < NUM_SAMPLES) ? 0 : 100;
            ml[a] = (a < NUM_SAMPLES) ? (a % 4) : 3;
        end
        mx[20] = 100; my[20] = 100; ml[20] = 1;
        run_scan(100, 100, 127, 5);
        finish_round(2, 1);
        chk("newq_class", 32'(got_class), 32'd1);
        chk("newq_dist", 32'(got_dist), 32'd0);

        // Randomised back-to-back rounds
        for (int r = 0; r < 10; r++) begin
            int span = (r % 2 == 0) ? 8 : 256;
            int qx = $urandom_range(span - 1);
            int qy = $urandom_range(span - 1);
            int last;
            case (r % 5)
                0: last = 0;
                1: last = 1;
                2: last = 2;
                3: last = 127;
                default: last = $urandom_range(3, 127);
            endcase
            for (int a = 0; a < 128; a++) begin
                if (a < NUM_SAMPLES) begin
                    mx[a] = $urandom_range(span - 1);
                    my[a] = $urandom_range(span - 1);
                    ml[a] = $urandom_range(3);
                end else begin
                    mx[a] = qx; my[a] = qy; ml[a] = 3;
                end
            end
            run_scan(qx, qy, last, $urandom_range(20));
            finish_round($urandom_range(2, 4), $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
